// File: rtl/umi_qos_arbiter.sv
// umi_qos_arbiter: N-to-1 arbiter for a shared UMI output channel.
// Each valid command is ranked by {starved, class, qos}. Requesters with equal
// keys are served round-robin. A multi-beat packet keeps its grant until an EOM
// beat is accepted. Per-requester age counters stop low-priority requesters
// from being starved.
module umi_qos_arbiter #(
    parameter int N    = 4,
    parameter int CW   = 32,
    parameter int AW   = 64,
    parameter int DW   = 256,
    parameter int AGEW = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    output logic [N-1:0]    grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = 6;
    localparam logic [AGEW-1:0] AGE_MAX = '1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   lock_id;
    logic [AGEW-1:0] age [N];

    logic [KW-1:0]   key [N];
    logic            win_found;
    logic [IW-1:0]   win_id;
    logic [KW-1:0]   best_key;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   ptr_inc;
    logic            xfer;
    logic            out_eom;

    // Build the priority key of every requester: {starved, class, qos}.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            key[i] = {age[i] == AGE_MAX, umi_in_cmd[i*CW], umi_in_cmd[i*CW+16 +: 4]};
        end
    end

    // Pick the highest key, scanning from rr_ptr so equal keys rotate.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        best_key  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            // Strictly greater keeps the first requester in round-robin order.
            if (umi_in_valid[idx] && (!win_found || key[idx] > best_key)) begin
                win_found = 1'b1;
                win_id    = idx;
                best_key  = key[idx];
            end
        end
    end

    // Grant follows the lock while a packet is open, else the live winner.
    always_comb begin
        grant  = '0;
        gnt_id = win_id;
        if (state == LOCKED) begin
            grant[lock_id] = 1'b1;
            gnt_id         = lock_id;
        end else if (win_found) begin
            grant[win_id] = 1'b1;
        end
    end

    // Route the granted requester's payload to the output.
    always_comb begin
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                umi_out_cmd     = umi_in_cmd[i*CW +: CW];
                umi_out_dstaddr = umi_in_dstaddr[i*AW +: AW];
                umi_out_srcaddr = umi_in_srcaddr[i*AW +: AW];
                umi_out_data    = umi_in_data[i*DW +: DW];
            end
        end
    end

    // Round-robin pointer moves one past the requester finishing its packet.
    always_comb begin
        logic [IW:0] nxt;
        nxt = {1'b0, gnt_id} + 1'b1;
        if (nxt >= (IW+1)'(N)) begin
            nxt = '0;
        end
        ptr_inc = nxt[IW-1:0];
    end

    assign umi_out_valid = |(grant & umi_in_valid);
    assign umi_in_ready  = grant & {N{umi_out_ready}};
    assign xfer          = umi_out_valid & umi_out_ready;
    assign out_eom       = umi_out_cmd[22];

    // Track the packet lock, the round-robin pointer and the ages of all requesters.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
            // NOTE: the age array is a small set of flops whose values drive
            // arbitration. Each entry must be reset. It is not a RAM that can
            // be left uninitialised.
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else if (xfer) begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the values from before the edge.
            if (out_eom) begin
                state  <= IDLE;
                rr_ptr <= ptr_inc;
                for (int i = 0; i < N; i++) begin
                    if (IW'(i) == gnt_id) begin
                        age[i] <= '0;
                    end else if (umi_in_valid[i] && age[i] != AGE_MAX) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end else if (state == IDLE) begin
                state   <= LOCKED;
                lock_id <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_umi_qos_arbiter.sv
// Directed bench for umi_qos_arbiter (N=4, AGEW=2). Inputs change 1 time unit
// after the rising edge. Outputs are sampled on the falling edge.
module tb_umi_qos_arbiter;

    localparam int N    = 4;
    localparam int CW   = 32;
    localparam int AW   = 64;
    localparam int DW   = 256;
    localparam int AGEW = 2;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    in_valid;
    logic [N*CW-1:0] in_cmd;
    logic [N*AW-1:0] in_dst;
    logic [N*AW-1:0] in_src;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic [AW-1:0]   out_dst;
    logic [AW-1:0]   out_src;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [N-1:0]    grant;

    int checks   = 0;
    int failures = 0;

    umi_qos_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .AGEW(AGEW)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .umi_in_valid   (in_valid),
        .umi_in_cmd     (in_cmd),
        .umi_in_dstaddr (in_dst),
        .umi_in_srcaddr (in_src),
        .umi_in_data    (in_data),
        .umi_in_ready   (in_ready),
        .umi_out_valid  (out_valid),
        .umi_out_cmd    (out_cmd),
        .umi_out_dstaddr(out_dst),
        .umi_out_srcaddr(out_src),
        .umi_out_data   (out_data),
        .umi_out_ready  (out_ready),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [31:0] c);
        in_cmd[i*CW +: CW] = c;
    endtask

    // Checks the grant vector and the routed destination address.
    task automatic check_grant(input string tag, input int idx);
        check({tag, "_grant"}, grant, 4'b0001 << idx);
        check({tag, "_dst"}, out_dst, 64'hD0D0_0000_0000_0000 | 64'(idx));
    endtask

    task automatic do_reset();
        nreset    = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        #3;
        nreset    = 1'b1;
    endtask

    initial begin
        int exp_rr [5];
        int exp_sv [5];
        int exp_ag [3];
        exp_rr = '{0, 1, 2, 3, 0};
        exp_sv = '{0, 0, 0, 1, 0};
        exp_ag = '{0, 0, 2};

        for (int i = 0; i < N; i++) begin
            in_dst[i*AW +: AW]  = 64'hD0D0_0000_0000_0000 | 64'(i);
            in_src[i*AW +: AW]  = 64'h5C5C_0000_0000_0000 | 64'(i);
            in_data[i*DW +: DW] = {8{32'hDA7A_0000 | 32'(i)}};
        end
        in_cmd    = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        nreset    = 1'b0;
        tick();
        tick();
        nreset = 1'b1;

        // Reset state: no valids means everything is quiet.
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_grant", grant, 4'b0000);
        check("rst_ready", in_ready, 4'b0000);
        tick();

        // Round-robin among equal keys.
        do_reset();
        in_valid  = 4'b1111;
        for (int i = 0; i < N; i++) set_cmd(i, 32'h0040_0002);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_grant($sformatf("rr%0d", c), exp_rr[c]);
            check($sformatf("rr%0d_rdy", c), in_ready, 4'b0001 << exp_rr[c]);
            tick();
        end

        // Class beats qos, then qos decides within a class.
        do_reset();
        in_valid = 4'b0011;
        set_cmd(0, 32'h0042_0000);
        set_cmd(1, 32'h0040_0001);
        @(negedge clk);
        check_grant("cls", 1);
        check("cls_rdy0", in_ready, 4'b0000);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("cls_rdy1", in_ready, 4'b0010);
        check("cls_cmd", out_cmd, 32'h0040_0001);
        tick();
        in_valid = 4'b1100;
        set_cmd(2, 32'h004F_0000);
        set_cmd(3, 32'h0043_0000);
        @(negedge clk);
        check_grant("qos", 2);
        tick();

        // Packet lock across a stall and a dropped valid.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        set_cmd(1, 32'h0000_0000);
        @(negedge clk);
        check_grant("lk_b1", 1);
        tick();
        in_valid  = 4'b1010;
        set_cmd(3, 32'h004F_0000);
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_grant($sformatf("lk_st%0d", c), 1);
            check($sformatf("lk_st%0d_rdy", c), in_ready, 4'b0000);
            check($sformatf("lk_st%0d_val", c), out_valid, 1'b1);
            check($sformatf("lk_st%0d_dat", c), out_data, {8{32'hDA7A_0001}});
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        @(negedge clk);
        check("lk_drop_val", out_valid, 1'b0);
        check("lk_drop_grant", grant, 4'b0010);
        tick();
        in_valid = 4'b1010;
        @(negedge clk);
        check_grant("lk_b2", 1);
        check("lk_b2_rdy", in_ready, 4'b0010);
        tick();
        set_cmd(1, 32'h0040_0000);
        @(negedge clk);
        check_grant("lk_b3", 1);
        tick();
        in_valid = 4'b1000;
        @(negedge clk);
        check_grant("lk_after", 3);
        tick();

        // Starvation: in1 reaches age 3 after three in0 completions.
        do_reset();
        in_valid  = 4'b0011;
        set_cmd(0, 32'h004F_0000);
        set_cmd(1, 32'h0040_0000);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_grant($sformatf("sv%0d", c), exp_sv[c]);
            tick();
        end

        // Reset asserted in the middle of a packet.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        set_cmd(2, 32'h0000_0000);
        @(negedge clk);
        check_grant("rm_b1", 2);
        tick();
        in_valid  = 4'b0101;
        set_cmd(0, 32'h0040_0000);
        out_ready = 1'b0;
        @(negedge clk);
        check_grant("rm_b2", 2);
        #1 nreset = 1'b0;
        #1;
        check_grant("rm_inrst", 0);
        #1 nreset = 1'b1;
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_grant("rm_post", 0);
        check("rm_post_val", out_valid, 1'b1);
        tick();

        // No valid inputs with ready toggling. The ages must survive.
        in_valid = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            out_ready = (c % 2 == 0);
            @(negedge clk);
            check($sformatf("nv%0d_val", c), out_valid, 1'b0);
            check($sformatf("nv%0d_grant", c), grant, 4'b0000);
            check($sformatf("nv%0d_rdy", c), in_ready, 4'b0000);
            tick();
        end
        // in2 carries age 1 from the completion above, so it starves on the third cycle.
        in_valid  = 4'b0101;
        set_cmd(0, 32'h004F_0000);
        set_cmd(2, 32'h0040_0000);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_grant($sformatf("ag%0d", c), exp_ag[c]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
